// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// One outstanding request; ack may arrive in the same cycle as req or later.
interface if_fetch_if;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_ack_i;
   logic [31:0] ibus_data_i;

   modport master (
      output ibus_req_o,
      output ibus_addr_o,
      input  ibus_ack_i,
      input  ibus_data_i
   );

   modport slave (
      input  ibus_req_o,
      input  ibus_addr_o,
      output ibus_ack_i,
      output ibus_data_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, keeps one request outstanding on the
// instruction bus and feeds the IF/ID register. Handles hold, jump flush and
// discard of responses made stale by a jump.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              hold_i,
   input  logic              jump_i,
   input  logic [31:0]       jump_addr_i,
   if_fetch_if.master        ibus,
   output logic [31:0]       inst_o,
   output logic [31:0]       inst_addr_o,
   output logic              inst_valid_o
);

   // StHeld: response captured in the buffer while downstream is stalled.
   // StDrain: waiting for the ack of a request made stale by a jump.
   typedef enum logic [1:0] {StFetch, StHeld, StDrain} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] buf_addr_q, buf_addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] jump_tgt;
   logic [31:0] fetch_addr_inc;

   assign jump_tgt       = jump_addr_i & 32'hFFFF_FFFC;
   assign fetch_addr_inc = fetch_addr_q + 32'd4;

   // Bus request is dropped combinationally while reset is asserted.
   assign ibus.ibus_req_o  = rst_ && (state_q != StHeld);
   assign ibus.ibus_addr_o = fetch_addr_q;

   assign inst_o       = inst_q;
   assign inst_addr_o  = inst_addr_q;
   assign inst_valid_o = inst_valid_q;

   // Next-state and next-output selection; jump overrides everything else.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      buf_inst_d   = buf_inst_q;
      buf_addr_d   = buf_addr_q;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;
      inst_valid_d = inst_valid_q;

      if (jump_i) begin
         inst_d       = NOP_INST;
         inst_addr_d  = 32'h0;
         inst_valid_d = 1'b0;
         pc_d         = jump_tgt;
         // Nothing outstanding, or the outstanding one completes now: redirect at once.
         if (state_q == StHeld || ibus.ibus_ack_i) begin
            fetch_addr_d = jump_tgt;
            state_d      = StFetch;
         end else begin
            state_d = StDrain;
         end
      end else begin
         unique case (state_q)
            StFetch: begin
               if (ibus.ibus_ack_i) begin
                  pc_d         = fetch_addr_inc;
                  fetch_addr_d = fetch_addr_inc;
                  if (hold_i) begin
                     buf_inst_d = ibus.ibus_data_i;
                     buf_addr_d = fetch_addr_q;
                     state_d    = StHeld;
                  end else begin
                     inst_d       = ibus.ibus_data_i;
                     inst_addr_d  = fetch_addr_q;
                     inst_valid_d = 1'b1;
                  end
               end else if (!hold_i) begin
                  inst_d       = NOP_INST;
                  inst_addr_d  = 32'h0;
                  inst_valid_d = 1'b0;
               end
            end
            StHeld: begin
               if (!hold_i) begin
                  inst_d       = buf_inst_q;
                  inst_addr_d  = buf_addr_q;
                  inst_valid_d = 1'b1;
                  state_d      = StFetch;
               end
            end
            StDrain: begin
               if (ibus.ibus_ack_i) begin
                  fetch_addr_d = pc_q;
                  state_d      = StFetch;
               end
               if (!hold_i) begin
                  inst_d       = NOP_INST;
                  inst_addr_d  = 32'h0;
                  inst_valid_d = 1'b0;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         buf_inst_q   <= NOP_INST;
         buf_addr_q   <= 32'h0;
         inst_q       <= NOP_INST;
         inst_addr_q  <= 32'h0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         buf_inst_q   <= buf_inst_d;
         buf_addr_q   <= buf_addr_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
         inst_valid_q <= inst_valid_d;
      end
   end

endmodule
